// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: shifts an N-bit word out MSB first, then pulses done.
// Define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] I,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 2);

`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif

    localparam logic [CW-1:0] LAST_CNT = CW'(LAST);
    localparam logic [CW-1:0] PAR_CNT  = CW'(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          done_nx;
    logic          sout_nx;
    logic          busy_nx;

`ifdef PISO_SHIFT_TX_PARITY_EN
    logic          par;
    logic          par_nx;
`endif

    // Next-state logic; outputs are precomputed here so they leave the block straight from flops.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
        par_nx   = par;
`endif

        case (state)
            IDLE: begin
                if (load) begin
                    state_nx = SHIFT;
                    shreg_nx = I;
                    cnt_nx   = '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
                    par_nx   = ^I;
`endif
                end
            end
            SHIFT: begin
                shreg_nx = shreg << 1;
                if (cnt == LAST_CNT) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx == SHIFT);
        sout_nx = 1'b1;
        if (state_nx == SHIFT) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            // Once all data bits are out the counter reaches N and the parity bit takes the line.
            if (cnt_nx == PAR_CNT) begin
                sout_nx = par_nx;
            end else begin
                sout_nx = shreg_nx[N-1];
            end
`else
            sout_nx = shreg_nx[N-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            sout  <= 1'b1;
            busy  <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            sout  <= sout_nx;
            busy  <= busy_nx;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

`ifndef PISO_SHIFT_TX_PARITY_EN
    logic unused_cnt_ok;
    assign unused_cnt_ok = &{1'b0, PAR_CNT};
`endif

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx with N=4.
// Expectations adapt when PISO_SHIFT_TX_PARITY_EN is defined.
module tb_piso_shift_tx;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] I;
    logic         sout;
    logic         busy;
    logic         done;

    int compared   = 0;
    int mismatched = 0;

    piso_shift_tx #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .I     (I),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the coming edge, then settle just past it.
    task automatic applyStimulus(input logic r, input logic l, input logic [N-1:0] d);
        reset = r;
        load  = l;
        I     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_sout,
                               input logic exp_busy, input logic exp_done);
        checkBit({tag, ".sout"}, sout, exp_sout);
        checkBit({tag, ".busy"}, busy, exp_busy);
        checkBit({tag, ".done"}, done, exp_done);
    endtask

    // Entered in the first cycle after the load edge; leaves the bench in the done cycle.
    task automatic checkWord(input string tag, input logic [N-1:0] word, input logic par_bit,
                             input logic hold_load, input logic [N-1:0] hold_I);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("%s.bit%0d", tag, k), word[N-1-k], 1'b1, 1'b0);
            applyStimulus(1'b0, hold_load, hold_I);
        end
`ifdef PISO_SHIFT_TX_PARITY_EN
        checkOutput({tag, ".parity"}, par_bit, 1'b1, 1'b0);
        applyStimulus(1'b0, hold_load, hold_I);
`else
        if (par_bit === 1'bx) $display("[TB] unexpected x parity for %s", tag);
`endif
        checkOutput({tag, ".done"}, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        I     = '0;
        applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 4'b1111);
        checkOutput("reset", 1'b1, 1'b0, 1'b0);

        // Basic word 1011, parity 1
        applyStimulus(1'b0, 1'b1, 4'b1011);
        checkWord("w1011", 4'b1011, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("w1011.after", 1'b1, 1'b0, 1'b0);

        // Word 1001, parity 0
        applyStimulus(1'b0, 1'b1, 4'b1001);
        checkWord("w1001", 4'b1001, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("w1001.after", 1'b1, 1'b0, 1'b0);

        // Load and I toggling while busy must not disturb the word in flight
        applyStimulus(1'b0, 1'b1, 4'b1100);
        checkWord("w1100", 4'b1100, 1'b0, 1'b1, 4'b0011);
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput("w1100.idle1", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput("w1100.idle2", 1'b1, 1'b0, 1'b0);

        // Reset aborts a word with no done pulse
        applyStimulus(1'b0, 1'b1, 4'b1111);
        checkOutput("abort.c1", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("abort.c2", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("abort.rst", 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
            checkOutput($sformatf("abort.quiet%0d", c), 1'b1, 1'b0, 1'b0);
        end

        // Reset wins over load, then load is accepted on the first edge after release
        applyStimulus(1'b1, 1'b1, 4'b1010);
        checkOutput("rstload", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'b0101);
        checkWord("w0101", 4'b0101, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("w0101.after", 1'b1, 1'b0, 1'b0);

        // Back-to-back words with load held high
        applyStimulus(1'b0, 1'b1, 4'b1010);
        checkWord("b2b1", 4'b1010, 1'b0, 1'b1, 4'b1010);
        applyStimulus(1'b0, 1'b1, 4'b0110);
        checkWord("b2b2", 4'b0110, 1'b0, 1'b1, 4'b0110);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("b2b.after", 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL provide parameter: N, 4, data word width in bits (N >= 1).
REQ-002 SHALL provide port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: load  input  1  request to capture I and start transmission; honoured only when idle.
REQ-005 SHALL provide port: I  input  N  parallel data word to transmit.
REQ-006 SHALL provide port: sout  output  1  serial data out, MSB first; idle level 1.
REQ-007 SHALL provide port: busy  output  1  high while a word is being shifted out.
REQ-008 SHALL provide port: done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-009 SHALL implement a two-state FSM, IDLE and SHIFT, with registered data shift register, bit counter and done flag; all outputs driven from registers, no combinational path from inputs to outputs.
REQ-010 In IDLE with load=1 at a rising edge, SHALL capture I into the shift register, clear the bit counter and enter SHIFT.
REQ-011 In IDLE, SHALL hold sout=1 and busy=0; load=0 keeps the FSM in IDLE.
REQ-012 In SHIFT, sout SHALL equal the current MSB of the shift register; each rising edge shifts left by one and increments the counter.
REQ-013 Latency: first data bit (I[N-1]) SHALL appear on sout in the cycle immediately after the load edge; bit I[N-1-k] SHALL appear in cycle k+1, k=0..N-1.
REQ-014 SHIFT SHALL last exactly N cycles (N+1 with parity, REQ-024); busy=1 for exactly those cycles.
REQ-015 Counter SHALL be clog2(N+2) bits wide and SHALL never wrap during a word; transition SHIFT->IDLE occurs on the edge ending the final bit cycle.
REQ-016 done SHALL be 1 for exactly the first IDLE cycle after a completed word, and 0 in all other cycles.
REQ-017 load asserted while busy=1 SHALL be ignored; I changes during SHIFT SHALL not affect the word in flight.
REQ-018 load asserted in the cycle done=1 SHALL be accepted (back-to-back words separated by exactly one idle cycle).
REQ-019 N=1 SHALL be supported: one data bit cycle, then done.

Reset
REQ-020 reset=1 at a rising edge SHALL force IDLE, sout=1, busy=0, done=0, counter=0, shift register=0.
REQ-021 reset SHALL take priority over load and over an in-progress word; a word aborted by reset SHALL NOT produce a done pulse.
REQ-022 After reset deasserts, SHALL accept load on the first following edge.

Configuration
REQ-023 Macro PISO_SHIFT_TX_PARITY_EN SHALL select parity append.
REQ-024 With PISO_SHIFT_TX_PARITY_EN defined, SHALL capture even parity (XOR of I) at load and drive it on sout for one extra cycle after the N data bits; busy spans N+1 cycles, done follows.
REQ-025 Without PISO_SHIFT_TX_PARITY_EN, SHALL emit only the N data bits; no parity storage present.

Verification (N=4)
REQ-026 Reset, then load=1 with I=4'b1011 for one edge -> cycles 1..4 sout=1,0,1,1, busy=1; cycle 5 busy=0, done=1, sout=1; cycle 6 done=0.
REQ-027 Parity build, I=4'b1011 -> cycles 1..4 sout=1,0,1,1, cycle 5 sout=1 (parity), cycle 6 done=1; I=4'b1001 -> parity cycle sout=0.
REQ-028 Load 4'b1100, then at cycle 2 pulse load with I=4'b0011 -> sout stays 1,1,0,0, single done, second word never transmitted.
REQ-029 Load 4'b1111, assert reset in cycle 2 -> next cycle sout=1, busy=0, done=0, no done pulse afterwards; subsequent load 4'b0101 transmits 0,1,0,1 normally.
REQ-030 Hold load=1 continuously with I=4'b1010 then 4'b0110 -> words 1,0,1,0 and 0,1,1,0 separated by one idle cycle with done=1.
